// File: rtl/gpa_fhdo_pkg.sv
// Constants and types shared between the GPA-FHDO DAC SPI receiver and transmitter.
package gpa_fhdo_pkg;

  localparam int unsigned FRAME_BITS = 24;

  localparam logic [3:0] ADDR_SYNC = 4'h2;
  localparam logic [3:0] ADDR_DAC0 = 4'h8;
  localparam logic [3:0] ADDR_DAC1 = 4'h9;
  localparam logic [3:0] ADDR_DAC2 = 4'hA;
  localparam logic [3:0] ADDR_DAC3 = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } spi_state_e;

  function automatic logic is_dac_addr(input logic [3:0] addr);
    return (addr[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one asynchronous SPI line, plus a one-cycle delayed copy for edge detection.
module spi_in_sync #(
  parameter int unsigned DEPTH   = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic q_dly
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stages <= {DEPTH{RST_VAL}};
      q_dly  <= RST_VAL;
    end else begin
      stages[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
      q_dly <= stages[DEPTH-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/fhdo_dac_spi_rx.sv
// SPI slave emulating the GPA-FHDO DAC register map: 24-bit write/read frames, four DAC codes and a SYNC register.
module fhdo_dac_spi_rx
  import gpa_fhdo_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RB_ENABLE   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fhd_clk_i,
  input  logic        fhd_sdo_i,
  input  logic        fhd_csn_i,
  output logic        fhd_sdi_o,
  output logic [15:0] dac0_o,
  output logic [15:0] dac1_o,
  output logic [15:0] dac2_o,
  output logic [15:0] dac3_o,
  output logic [15:0] sync_reg_o,
  output logic        frame_valid_o,
  output logic        frame_err_o,
  output logic [3:0]  last_addr_o,
  output logic [7:0]  err_cnt_o
);

  spi_state_e state, state_nxt;

  logic        sclk_s, sclk_d, csn_s, csn_d, sdo_s, sdo_dly_unused;
  logic [7:0]  warm;
  logic        ready;
  logic        csn_fall, csn_rise, sclk_fall, sclk_rise;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] rb_sr;
  logic [4:0]  bit_cnt;
  logic        armed;
  logic        frame_full, mapped, err_inc;
  logic        frm_read;
  logic [2:0]  rsvd_unused;
  logic [3:0]  frm_addr;
  logic [15:0] frm_data, rd_data;

  spi_in_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .d(fhd_clk_i), .q(sclk_s), .q_dly(sclk_d)
  );
  spi_in_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rst_n(rst_n), .d(fhd_csn_i), .q(csn_s), .q_dly(csn_d)
  );
  spi_in_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdo (
    .clk(clk), .rst_n(rst_n), .d(fhd_sdo_i), .q(sdo_s), .q_dly(sdo_dly_unused)
  );

  // The synchroniser resets to CSN high, so a bus already held low would look like a
  // fresh falling edge; CSN edges count only once the pipeline holds real samples.
  assign ready     = (warm == 8'(SYNC_STAGES + 1));
  assign csn_fall  = ready & csn_d & ~csn_s;
  assign csn_rise  = ready & ~csn_d & csn_s;
  assign sclk_fall = sclk_d & ~sclk_s;
  assign sclk_rise = ~sclk_d & sclk_s;

  assign frm_read    = shreg[23];
  assign rsvd_unused = shreg[22:20];
  assign frm_addr    = shreg[19:16];
  assign frm_data    = shreg[15:0];

  always_comb begin
    state_nxt  = state;
    frame_full = 1'b0;
    unique case (state)
      ST_IDLE:  if (csn_fall) state_nxt = ST_SHIFT;
      ST_SHIFT: if (csn_rise) state_nxt = ST_DONE;
      ST_DONE: begin
        state_nxt  = ST_IDLE;
        frame_full = (bit_cnt == 5'(FRAME_BITS));
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    mapped  = 1'b1;
    if (frm_addr == ADDR_SYNC) begin
      rd_data = sync_reg_o;
    end else if (is_dac_addr(frm_addr)) begin
      unique case (frm_addr[1:0])
        2'd0: rd_data = dac0_o;
        2'd1: rd_data = dac1_o;
        2'd2: rd_data = dac2_o;
        default: rd_data = dac3_o;
      endcase
    end else begin
      mapped = 1'b0;
    end
    err_inc = (state == ST_DONE) && (!frame_full || (!frm_read && !mapped));
  end

  always_comb begin
    fhd_sdi_o = 1'b0;
    if ((RB_ENABLE != 0) && armed && (state == ST_SHIFT) && !csn_s)
      fhd_sdi_o = rb_sr[FRAME_BITS-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      warm          <= '0;
      shreg         <= '0;
      bit_cnt       <= '0;
      rb_sr         <= '0;
      armed         <= 1'b0;
      dac0_o        <= '0;
      dac1_o        <= '0;
      dac2_o        <= '0;
      dac3_o        <= '0;
      sync_reg_o    <= '0;
      frame_valid_o <= 1'b0;
      frame_err_o   <= 1'b0;
      last_addr_o   <= '0;
      err_cnt_o     <= '0;
    end else begin
      state         <= state_nxt;
      frame_valid_o <= 1'b0;
      frame_err_o   <= 1'b0;
      if (!ready) warm <= warm + 8'd1;

      if (state == ST_IDLE && csn_fall) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end

      if (state == ST_SHIFT && !csn_s) begin
        if (sclk_fall) begin
          if (bit_cnt < 5'(FRAME_BITS)) begin
            shreg   <= {shreg[FRAME_BITS-2:0], sdo_s};
            bit_cnt <= bit_cnt + 5'd1;
          end else begin
            bit_cnt <= 5'(FRAME_BITS + 1);
          end
        end
        if (sclk_rise && armed) rb_sr <= {rb_sr[FRAME_BITS-2:0], 1'b0};
      end

      if (state == ST_DONE) begin
        armed <= 1'b0;
        if (frame_full) begin
          frame_valid_o <= 1'b1;
          last_addr_o   <= frm_addr;
          if (frm_read) begin
            armed <= 1'b1;
            rb_sr <= {1'b1, 3'b000, frm_addr, rd_data};
          end else begin
            unique case (frm_addr)
              ADDR_SYNC: sync_reg_o <= frm_data;
              ADDR_DAC0: dac0_o     <= frm_data;
              ADDR_DAC1: dac1_o     <= frm_data;
              ADDR_DAC2: dac2_o     <= frm_data;
              ADDR_DAC3: dac3_o     <= frm_data;
              default: ;
            endcase
          end
        end else begin
          frame_err_o <= 1'b1;
        end
        if (err_inc && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fhdo_dac_spi_rx.sv
// Directed bench for fhdo_dac_spi_rx: the bench acts as SPI master and checks against a frame-level register model.
module tb_fhdo_dac_spi_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        sdo = 1'b0;
  logic        csn = 1'b1;
  logic        sdi;
  logic [15:0] dac0, dac1, dac2, dac3, sync_reg;
  logic        fv, fe;
  logic [3:0]  last_addr;
  logic [7:0]  err_cnt;

  fhdo_dac_spi_rx #(.SYNC_STAGES(2), .RB_ENABLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .fhd_clk_i(sclk), .fhd_sdo_i(sdo), .fhd_csn_i(csn), .fhd_sdi_o(sdi),
    .dac0_o(dac0), .dac1_o(dac1), .dac2_o(dac2), .dac3_o(dac3),
    .sync_reg_o(sync_reg), .frame_valid_o(fv), .frame_err_o(fe),
    .last_addr_o(last_addr), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fv_seen = 0;
  int fe_seen = 0;

  // register-map model, updated once per completed frame
  logic [15:0] m_dac [4];
  logic [15:0] m_sync;
  logic [3:0]  m_last;
  logic [7:0]  m_err;
  logic        m_armed;
  logic [23:0] m_rb;
  logic        exp_fv, exp_fe;
  int          pend = 0;
  logic [23:0] pend_word;
  int          pend_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dac[i] = 16'h0;
    m_sync = 16'h0; m_last = 4'h0; m_err = 8'h0; m_armed = 1'b0; m_rb = 24'h0;
  endtask

  task automatic err_bump();
    if (m_err < 8'd255) m_err = m_err + 8'd1;
  endtask

  task automatic model_apply(input logic [23:0] w, input int n);
    logic [3:0]  a;
    logic [15:0] rd;
    a = w[19:16];
    if (n == 24) begin
      exp_fv = 1'b1;
      m_last = a;
      if (a == 4'd2)                  rd = m_sync;
      else if (a >= 4'd8 && a <= 4'd11) rd = m_dac[a - 8];
      else                            rd = 16'h0;
      if (w[23]) begin
        m_armed = 1'b1;
        m_rb    = {1'b1, 3'b000, a, rd};
      end else begin
        m_armed = 1'b0;
        if (a == 4'd2)                  m_sync = w[15:0];
        else if (a >= 4'd8 && a <= 4'd11) m_dac[a - 8] = w[15:0];
        else                            err_bump();
      end
    end else begin
      exp_fe  = 1'b1;
      m_armed = 1'b0;
      err_bump();
    end
  endtask

  // frame results appear 1 + 2 sync + 1 cycles after the physical CSN rise
  always @(posedge clk) begin
    #1;
    exp_fv = 1'b0;
    exp_fe = 1'b0;
    if (!rst_n) begin
      model_reset();
      pend = 0;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) model_apply(pend_word, pend_n);
    end
    if (fv) fv_seen++;
    if (fe) fe_seen++;
    check("dac0", dac0, m_dac[0]);
    check("dac1", dac1, m_dac[1]);
    check("dac2", dac2, m_dac[2]);
    check("dac3", dac3, m_dac[3]);
    check("sync_reg", sync_reg, m_sync);
    check("last_addr", last_addr, m_last);
    check("err_cnt", err_cnt, m_err);
    check("frame_valid", fv, exp_fv);
    check("frame_err", fe, exp_fe);
    if (!m_armed) check("sdi_idle", sdi, 1'b0);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master: data changes on SCLK rise, MISO sampled just before each rise.
  task automatic send(input logic [23:0] w, input int nbits, input int half,
                      input int rst_at, output logic [23:0] got);
    logic [23:0] exp_rb;
    got = 24'h0;
    @(negedge clk);
    exp_rb = m_armed ? m_rb : 24'h0;
    csn = 1'b0;
    wait_cycles(6);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        check("rst_dac0", dac0, 16'h0);
        check("rst_dac1", dac1, 16'h0);
        check("rst_sync", sync_reg, 16'h0);
        check("rst_err", err_cnt, 8'h0);
        check("rst_last", last_addr, 4'h0);
        check("rst_sdi", sdi, 1'b0);
      end
      if (i < 24) got[23 - i] = sdi;
      sdo  = (i < 24) ? w[23 - i] : 1'b0;
      sclk = 1'b1;
      wait_cycles(half);
      sclk = 1'b0;
      wait_cycles(half);
    end
    wait_cycles(half);
    csn = 1'b1;
    sdo = 1'b0;
    if (rst_at < 0) begin
      pend_word = w;
      pend_n    = nbits;
      pend      = 4;
    end
    wait_cycles(8);
    if (half >= 4 && nbits == 24 && rst_at < 0) check("miso_word", got, exp_rb);
  endtask

  initial begin
    logic [23:0] got;
    int fv0, fe0;
    model_reset();
    exp_fv = 1'b0;
    exp_fe = 1'b0;
    wait_cycles(3);
    check("reset_dac0", dac0, 16'h0);
    check("reset_err", err_cnt, 8'h0);
    rst_n = 1'b1;
    wait_cycles(5);

    fv0 = fv_seen;
    send(24'h081234, 24, 2, -1, got);
    check("w1_dac0", dac0, 16'h1234);
    check("w1_last", last_addr, 4'h8);
    check("w1_pulses", fv_seen - fv0, 1);

    fv0 = fv_seen;
    send(24'h020000, 24, 2, -1, got);
    send(24'h0ABEEF, 24, 2, -1, got);
    check("w2_sync", sync_reg, 16'h0);
    check("w2_dac2", dac2, 16'hBEEF);
    check("w2_pulses", fv_seen - fv0, 2);

    fe0 = fe_seen;
    send(24'h0B1111, 13, 2, -1, got);
    check("short_err", err_cnt, 8'd1);
    check("short_dac3", dac3, 16'h0);
    check("short_dac0", dac0, 16'h1234);
    check("short_pulse", fe_seen - fe0, 1);

    send(24'h880000, 24, 4, -1, got);
    send(24'h095555, 24, 4, -1, got);
    check("rb_dac0", got, 24'h881234);
    check("rb_dac1", dac1, 16'h5555);

    fv0 = fv_seen;
    send(24'h05FFFF, 24, 2, -1, got);
    check("unmapped_pulse", fv_seen - fv0, 1);
    check("unmapped_err", err_cnt, 8'd2);
    check("unmapped_last", last_addr, 4'h5);

    send(24'h870000, 24, 4, -1, got);
    send(24'h0B0001, 24, 4, -1, got);
    check("rb_unmapped", got, 24'h870000);
    send(24'h020042, 24, 4, -1, got);
    check("rb_cleared", got, 24'h0);

    send(24'h09AAAA, 25, 2, -1, got);
    check("long_err", err_cnt, 8'd3);
    send(24'h000000, 0, 2, -1, got);
    check("empty_err", err_cnt, 8'd4);

    fv0 = fv_seen;
    fe0 = fe_seen;
    send(24'h09AAAA, 24, 2, 10, got);
    check("partial_no_fv", fv_seen - fv0, 0);
    check("partial_no_fe", fe_seen - fe0, 0);
    send(24'h09AAAA, 24, 2, -1, got);
    check("post_rst_dac1", dac1, 16'hAAAA);
    check("post_rst_pulse", fv_seen - fv0, 1);

    for (int k = 0; k < 256; k++) send(24'h000000, 0, 2, -1, got);
    check("err_saturated", err_cnt, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
